// File: rtl/mem_stage_lsu_if.sv
// Data-memory port of the MEM-stage load/store unit.
// master = LSU, slave = data memory.
interface mem_stage_lsu_if;
    // dm_req rises with dm_we/dm_addr/dm_be/dm_wdata valid and holds them stable
    // until the edge that samples dm_ack; dm_ack is a one-cycle pulse and
    // dm_rdata is valid only in that cycle.
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [3:0]  dm_be;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;

    modport master (
        output dm_req, dm_we, dm_addr, dm_be, dm_wdata,
        input  dm_ack, dm_rdata
    );

    modport slave (
        input  dm_req, dm_we, dm_addr, dm_be, dm_wdata,
        output dm_ack, dm_rdata
    );
endinterface

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: req/ack data-memory transaction, byte lanes, load extension.
// Optional feature macro: LSU_STAT_EN (cumulative stall-cycle counter on stat_stall_cnt).
module mem_stage_lsu #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic                  valid_in,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [2:0]            funct3,
    input  logic [31:0]           addr,
    input  logic [31:0]           wdata,
    mem_stage_lsu_if.master       dm,
    output logic                  stall,
    output logic [31:0]           load_data,
    output logic                  done,
    output logic                  misalign,
    output logic                  bus_err,
    output logic [31:0]           stat_stall_cnt,
    output logic [1:0]            fsm_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        start;
    logic        is_byte;
    logic        is_half;
    logic        mis_addr;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;

    logic [7:0]  cnt;
    logic [1:0]  lo_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [31:0] shifted;
    logic [31:0] ext;
    logic        expire;

    // funct3[1:0] alone selects the size, so illegal codes fall through to word.
    always_comb begin
        start     = valid_in & (mem_read | mem_write);
        is_byte   = (funct3[1:0] == 2'b00);
        is_half   = (funct3[1:0] == 2'b01);
        mis_addr  = (is_half & addr[0]) | (!is_byte && !is_half && addr[1:0] != 2'b00);
        be_new    = 4'b1111;
        wdata_new = wdata;
        if (is_byte) begin
            be_new    = 4'b0001 << addr[1:0];
            wdata_new = {4{wdata[7:0]}};
        end else if (is_half) begin
            be_new    = addr[1] ? 4'b1100 : 4'b0011;
            wdata_new = {2{wdata[15:0]}};
        end
    end

    always_comb begin
        shifted = dm.dm_rdata >> {lo_q, 3'b000};
        case (size_q)
            2'b00:   ext = uns_q ? {24'd0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   ext = uns_q ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            default: ext = dm.dm_rdata;
        endcase
    end

    assign expire = (cnt == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK) begin
        if (Reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        stall      = 1'b0;
        done       = 1'b0;
        misalign   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (mis_addr) begin
                        misalign = 1'b1;
                    end else begin
                        stall      = 1'b1;
                        state_next = REQ;
                    end
                end
            end
            REQ: begin
                stall = 1'b1;
                if (dm.dm_ack || expire) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign fsm_state = state;

    // An ack arriving on the timeout edge still completes the access normally.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            dm.dm_req   <= 1'b0;
            dm.dm_we    <= 1'b0;
            dm.dm_addr  <= 32'd0;
            dm.dm_be    <= 4'd0;
            dm.dm_wdata <= 32'd0;
            load_data   <= 32'd0;
            bus_err     <= 1'b0;
            cnt         <= 8'd0;
            lo_q        <= 2'd0;
            size_q      <= 2'd0;
            uns_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (state_next == REQ) begin
                        dm.dm_req   <= 1'b1;
                        dm.dm_we    <= mem_write;
                        dm.dm_addr  <= {addr[31:2], 2'b00};
                        dm.dm_be    <= be_new;
                        dm.dm_wdata <= wdata_new;
                        load_data   <= 32'd0;
                        cnt         <= 8'd0;
                        lo_q        <= addr[1:0];
                        size_q      <= funct3[1:0];
                        uns_q       <= funct3[2];
                    end
                end
                REQ: begin
                    if (dm.dm_ack) begin
                        dm.dm_req <= 1'b0;
                        load_data <= dm.dm_we ? 32'd0 : ext;
                    end else if (expire) begin
                        dm.dm_req <= 1'b0;
                        bus_err   <= 1'b1;
                        load_data <= 32'd0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DONE: bus_err <= 1'b0;
                default: ;
            endcase
        end
    end

`ifdef LSU_STAT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge CLK) begin
        if (Reset)      stall_cnt_q <= 32'd0;
        else if (stall) stall_cnt_q <= stall_cnt_q + 32'd1;
    end

    assign stat_stall_cnt = stall_cnt_q;
`else
    assign stat_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Randomised scoreboard bench for mem_stage_lsu with a behavioural memory responder.
module tb_mem_stage_lsu;

    localparam int TO = 4;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        valid_in, mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        stall, done, misalign, bus_err;
    logic [31:0] load_data, stat_stall_cnt;
    logic [1:0]  fsm_state;

    mem_stage_lsu_if dm_bus ();

    mem_stage_lsu #(.TIMEOUT_CYCLES(TO)) dut (
        .CLK(CLK), .Reset(Reset), .valid_in(valid_in), .mem_read(mem_read),
        .mem_write(mem_write), .funct3(funct3), .addr(addr), .wdata(wdata),
        .dm(dm_bus), .stall(stall), .load_data(load_data), .done(done),
        .misalign(misalign), .bus_err(bus_err), .stat_stall_cnt(stat_stall_cnt),
        .fsm_state(fsm_state)
    );

    // ---------------- clock / reset ----------------
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          delay;
        logic [31:0] rdata;
        int          len;
    } req_t;

    req_t        req_q[$];
    logic [32:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          exp_stall_total = 0;
    bit          inject_ack = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int size_of(input logic [2:0] f3);
        if (f3 == 3'b000 || f3 == 3'b100) return 1;
        if (f3 == 3'b001 || f3 == 3'b101) return 2;
        return 4;
    endfunction

    function automatic bit ref_misaligned(input logic [2:0] f3, input logic [31:0] a);
        int sz;
        sz = size_of(f3);
        return (sz == 2 && (a % 32'd2) != 0) || (sz == 4 && (a % 32'd4) != 0);
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] a);
        int off;
        off = int'(a % 32'd4);
        case (size_of(f3))
            1:       return 4'b0001 << off;
            2:       return (off >= 2) ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] wd);
        case (size_of(f3))
            1:       return (wd & 32'hFF) * 32'h0101_0101;
            2:       return (wd & 32'hFFFF) * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
        int          off;
        logic [31:0] v;
        off = int'(a % 32'd4);
        case (size_of(f3))
            1: begin
                v = (rd >> (8 * off)) & 32'hFF;
                if (f3 == 3'b000 && v >= 32'd128) v = v + 32'hFFFF_FF00;
            end
            2: begin
                v = (rd >> (8 * off)) & 32'hFFFF;
                if (f3 == 3'b001 && v >= 32'h8000) v = v + 32'hFFFF_0000;
            end
            default: v = rd;
        endcase
        return v;
    endfunction

    // ---------------- memory responder ----------------
    initial begin
        bit   active;
        int   cyc;
        req_t cur;
        active = 1'b0;
        cyc    = 0;
        dm_bus.dm_ack   = 1'b0;
        dm_bus.dm_rdata = 32'd0;
        forever begin
            @(negedge CLK);
            dm_bus.dm_ack = 1'b0;
            if (inject_ack) begin
                dm_bus.dm_ack   = 1'b1;
                dm_bus.dm_rdata = $urandom;
                inject_ack      = 1'b0;
            end else if (dm_bus.dm_req === 1'b1 && Reset === 1'b0) begin
                if (!active) begin
                    active = 1'b1;
                    cyc    = 0;
                    if (req_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_req: actual=request expected=none");
                        cur.delay = 0;
                        cur.len   = -1;
                    end else begin
                        cur = req_q.pop_front();
                    end
                end
                if (cur.len != -1 || cyc == 0) begin
                    check("dm_addr", dm_bus.dm_addr, cur.addr);
                    check("dm_we", {31'd0, dm_bus.dm_we}, {31'd0, cur.we});
                    check("dm_be", {28'd0, dm_bus.dm_be}, {28'd0, cur.be});
                    if (cur.we) check("dm_wdata", dm_bus.dm_wdata, cur.wdata);
                end
                if (cur.delay == cyc) begin
                    dm_bus.dm_ack   = 1'b1;
                    dm_bus.dm_rdata = cur.rdata;
                end
                cyc++;
            end else if (active) begin
                active = 1'b0;
                if (cur.len >= 0) check("req_cycles", cyc, cur.len);
            end
        end
    end

    // ---------------- response monitor ----------------
    initial begin
        logic [32:0] e;
        forever begin
            @(negedge CLK);
            if (done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: actual=done expected=none");
                end else begin
                    e = exp_q.pop_front();
                    check("load_data", load_data, e[31:0]);
                    check("bus_err", {31'd0, bus_err}, {31'd0, e[32]});
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic apply(input bit rd, input bit wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input bit v);
        @(posedge CLK);
        #1;
        valid_in  = v;
        mem_read  = rd;
        mem_write = wr;
        funct3    = f3;
        addr      = a;
        wdata     = wd;
    endtask

    task automatic release_inputs();
        @(posedge CLK);
        #1;
        valid_in  = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    // delay < 0: the memory never acks and the access must time out.
    task automatic do_access(input bit rd, input bit wr, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] rdata, input int delay);
        req_t        r;
        bit          got;
        bit          timeout;
        int          n_stall;
        int          exp_stall;
        logic [31:0] exp_ld;
        if (ref_misaligned(f3, a)) begin
            apply(rd, wr, f3, a, wd, 1'b1);
            @(negedge CLK);
            check("misalign", {31'd0, misalign}, 32'd1);
            check("misalign_stall", {31'd0, stall}, 32'd0);
            check("misalign_req", {31'd0, dm_bus.dm_req}, 32'd0);
            check("misalign_done", {31'd0, done}, 32'd0);
            release_inputs();
            @(negedge CLK);
            check("misalign_req_after", {31'd0, dm_bus.dm_req}, 32'd0);
            return;
        end
        timeout = (delay < 0);
        r.addr  = a & 32'hFFFF_FFFC;
        r.we    = wr;
        r.be    = ref_be(f3, a);
        r.wdata = ref_wdata(f3, wd);
        r.delay = delay;
        r.rdata = rdata;
        r.len   = timeout ? TO : delay + 1;
        req_q.push_back(r);
        exp_ld = (wr || timeout) ? 32'd0 : ref_load(f3, a, rdata);
        exp_q.push_back({timeout, exp_ld});
        exp_stall = r.len + 1;
        exp_stall_total += exp_stall;

        apply(rd, wr, f3, a, wd, 1'b1);
        n_stall = 0;
        got     = 1'b0;
        for (int i = 0; i < TO + 8 && !got; i++) begin
            @(negedge CLK);
            if (done === 1'b1) got = 1'b1;
            else if (stall === 1'b1) n_stall++;
        end
        check("done_seen", {31'd0, got}, 32'd1);
        check("stall_cycles", n_stall, exp_stall);
        check("done_stall_low", {31'd0, stall}, 32'd0);
        release_inputs();
        @(negedge CLK);
        check("done_one_cycle", {31'd0, done}, 32'd0);
        check("idle_no_req", {31'd0, dm_bus.dm_req}, 32'd0);
        check("bus_err_cleared", {31'd0, bus_err}, 32'd0);
    endtask

    task automatic idle_check(input bit v, input bit rd, input bit wr);
        apply(rd, wr, 3'b010, 32'h0000_0400, 32'd0, v);
        repeat (2) begin
            @(negedge CLK);
            check("idle_stall", {31'd0, stall}, 32'd0);
            check("idle_req", {31'd0, dm_bus.dm_req}, 32'd0);
        end
        release_inputs();
    endtask

    task automatic reset_mid_req();
        req_t r;
        bit   seen;
        r.addr  = 32'h0000_0300;
        r.we    = 1'b0;
        r.be    = 4'b1111;
        r.wdata = 32'd0;
        r.delay = -1;
        r.rdata = 32'd0;
        r.len   = -1;
        req_q.push_back(r);
        apply(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'd0, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 4 && !seen; i++) begin
            @(negedge CLK);
            if (dm_bus.dm_req === 1'b1) seen = 1'b1;
        end
        check("rst_req_seen", {31'd0, seen}, 32'd1);
        @(posedge CLK);
        #1;
        Reset = 1'b1;
        @(posedge CLK);
        #1;
        Reset      = 1'b0;
        valid_in   = 1'b0;
        mem_read   = 1'b0;
        inject_ack = 1'b1;
        exp_stall_total = 0;
        @(negedge CLK);
`ifdef LSU_STAT_EN
        check("stat_after_reset", stat_stall_cnt, 32'd0);
`endif
        repeat (4) begin
            @(negedge CLK);
            check("rst_done_low", {31'd0, done}, 32'd0);
            check("rst_req_low", {31'd0, dm_bus.dm_req}, 32'd0);
            check("rst_stall_low", {31'd0, stall}, 32'd0);
        end
        check("rst_load_data", load_data, 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int          k;
        bit          rd, wr;
        logic [2:0]  f3;
        logic [31:0] a;
        int          delay;

        Reset     = 1'b1;
        valid_in  = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        funct3    = 3'b000;
        addr      = 32'd0;
        wdata     = 32'd0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_dm_req", {31'd0, dm_bus.dm_req}, 32'd0);
        check("rst_dm_we", {31'd0, dm_bus.dm_we}, 32'd0);
        check("rst_dm_be", {28'd0, dm_bus.dm_be}, 32'd0);
        check("rst_dm_addr", dm_bus.dm_addr, 32'd0);
        check("rst_dm_wdata", dm_bus.dm_wdata, 32'd0);
        check("rst_load_data", load_data, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_misalign", {31'd0, misalign}, 32'd0);
        check("rst_bus_err", {31'd0, bus_err}, 32'd0);
        check("rst_stat", stat_stall_cnt, 32'd0);
        @(posedge CLK);
        #1;
        Reset = 1'b0;

        do_access(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'd0, 32'hDEAD_BEEF, 0);
        do_access(1'b1, 1'b0, 3'b000, 32'h0000_0203, 32'd0, 32'h80FF_1234, 1);
        do_access(1'b1, 1'b0, 3'b100, 32'h0000_0203, 32'd0, 32'h80FF_1234, 0);
        do_access(1'b1, 1'b0, 3'b101, 32'h0000_0202, 32'd0, 32'h80FF_1234, 2);
        do_access(1'b1, 1'b0, 3'b001, 32'h0000_0202, 32'd0, 32'h80FF_1234, 0);
        do_access(1'b0, 1'b1, 3'b000, 32'h0000_0011, 32'h0000_00AB, 32'd0, 0);
        do_access(1'b0, 1'b1, 3'b001, 32'h0000_0012, 32'h0000_1234, 32'd0, 1);
        do_access(1'b1, 1'b1, 3'b010, 32'h0000_0020, 32'hCAFE_F00D, 32'h1111_1111, 0);
        do_access(1'b1, 1'b0, 3'b110, 32'h0000_0024, 32'd0, 32'h8765_4321, TO - 1);
        do_access(1'b1, 1'b0, 3'b010, 32'h0000_0102, 32'd0, 32'd0, 0);
        do_access(1'b1, 1'b0, 3'b001, 32'h0000_0101, 32'd0, 32'd0, 0);
        do_access(1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'd0, 32'h5555_5555, -1);
        do_access(1'b0, 1'b1, 3'b000, 32'h0000_0041, 32'h0000_0077, 32'd0, -1);

        idle_check(1'b1, 1'b0, 1'b0);
        idle_check(1'b0, 1'b1, 1'b0);
        idle_check(1'b0, 1'b0, 1'b1);

        reset_mid_req();

        for (int n = 0; n < 60; n++) begin
            k  = $urandom_range(0, 2);
            rd = (k != 1);
            wr = (k != 0);
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (size_of(f3) == 2) a = a & 32'hFFFF_FFFE;
                if (size_of(f3) == 4) a = a & 32'hFFFF_FFFC;
            end
            delay = ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(0, TO - 1);
            do_access(rd, wr, f3, a, $urandom, $urandom, delay);
        end

        repeat (3) @(negedge CLK);
        check("exp_q_drained", exp_q.size(), 32'd0);
        check("req_q_drained", req_q.size(), 32'd0);
`ifdef LSU_STAT_EN
        check("stat_total", stat_stall_cnt, exp_stall_total);
`else
        check("stat_tied_zero", stat_stall_cnt, 32'd0);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
